// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    // Width of the latency and starvation counters (legal limits 1..15)
    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    // Which requester owns the access in flight
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Narrow an integer parameter to the counter width
    function automatic cnt_t to_cnt(input int value);
        return cnt_t'(value);
    endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Small saturating up-counter with synchronous clear; the count parks at
// 'limit' until cleared. Used for both the fetch starvation guard and the
// memory read latency timer.
module arb_sat_counter
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    input  cnt_t limit,
    output cnt_t count
);

    // Clear wins over increment; increment stops once the limit is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != limit)) begin
            count <= count + cnt_t'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch
// (I port) and load/store (D port). Data accesses win arbitration unless
// fetch has lost STARVE_MAX times in a row. Each access runs
// IDLE -> ACCESS -> DONE, so there is always at least one idle cycle
// between grants. All outputs come straight from registers.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Read completes at the end of the MEM_LAT-th ACCESS cycle; the
    // latency counter starts at 0 in the first ACCESS cycle.
    localparam cnt_t LAT_LAST     = to_cnt(MEM_LAT - 1);
    localparam cnt_t STARVE_LIMIT = to_cnt(STARVE_MAX);

    arb_state_t state;
    owner_t     owner;
    logic       is_write;

    cnt_t       starve_cnt;
    cnt_t       lat_cnt;

    logic       grant_i;
    logic       grant_d;
    logic       fetch_lost;
    logic       access_end;
    logic       lat_clear;
    logic       lat_inc;

    // Arbitration and access-completion decisions for the current cycle
    always_comb begin
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        if (state == ARB_IDLE) begin
            if (i_req && (!d_req || (starve_cnt == STARVE_LIMIT))) begin
                grant_i = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
        fetch_lost = grant_d && i_req;
        access_end = (state == ARB_ACCESS) && (is_write || (lat_cnt == LAT_LAST));
        lat_clear  = (state != ARB_ACCESS);
        lat_inc    = (state == ARB_ACCESS) && !is_write;
    end

    // Counts consecutive arbitrations fetch lost while requesting
    arb_sat_counter u_starve_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .clear (grant_i),
        .inc   (fetch_lost),
        .limit (STARVE_LIMIT),
        .count (starve_cnt)
    );

    // Counts cycles spent waiting for read data in ACCESS
    arb_sat_counter u_lat_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .clear (lat_clear),
        .inc   (lat_inc),
        .limit (LAT_LAST),
        .count (lat_cnt)
    );

    // Sequencer: latches the winning request and produces the one-cycle
    // gnt, mem_wr and done pulses; busy tracks the next state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ARB_IDLE;
            owner     <= OWN_I;
            is_write  <= 1'b0;
            i_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            i_gnt  <= 1'b0;
            d_gnt  <= 1'b0;
            i_done <= 1'b0;
            d_done <= 1'b0;
            mem_wr <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_i) begin
                        state    <= ARB_ACCESS;
                        owner    <= OWN_I;
                        is_write <= 1'b0;
                        mem_addr <= i_addr;
                        i_gnt    <= 1'b1;
                        busy     <= 1'b1;
                    end else if (grant_d) begin
                        state     <= ARB_ACCESS;
                        owner     <= OWN_D;
                        is_write  <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wr    <= d_we;
                        d_gnt     <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ARB_ACCESS: begin
                    if (access_end) begin
                        state <= ARB_DONE;
                        if (owner == OWN_I) begin
                            i_done <= 1'b1;
                        end else begin
                            d_done <= 1'b1;
                        end
                    end
                end
                ARB_DONE: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Captures read data into the owner's register only; the other port's
    // read data is left untouched
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (access_end && !is_write) begin
            if (owner == OWN_I) begin
                i_rdata <= mem_rdata;
            end else begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule
